// File: rtl/ex_muldiv_unit_if.sv
// Issue/complete bus between the execution stage and the multiply/divide unit.
// The master side is the pipeline; the slave side is the unit.
interface ex_muldiv_unit_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    logic              start_i;
    logic [2:0]        op_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic [TAG_W-1:0]  tag_i;
    logic              flush_i;
    logic              ready_o;
    logic              busy_o;
    logic              stallreq_o;
    logic              done_o;
    logic [DATA_W-1:0] result_o;
    logic [TAG_W-1:0]  tag_o;

    modport master (
        output start_i, op_i, src1_i, src2_i, tag_i, flush_i,
        input  ready_o, busy_o, stallreq_o, done_o, result_o, tag_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i, tag_i, flush_i,
        output ready_o, busy_o, stallreq_o, done_o, result_o, tag_o
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle integer multiply/divide unit: fixed-latency multiplier plus a
// radix-2 restoring divider, one operation in flight, with flush and stall request.
module ex_muldiv_unit #(
    parameter int DATA_W     = 32,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 5
) (
    input  logic                clk,
    input  logic                rst,
    ex_muldiv_unit_if.slave     bus
);
    localparam int CNT_W = $clog2((DATA_W > MUL_STAGES) ? DATA_W : MUL_STAGES) + 1;
    localparam logic [DATA_W-1:0] MIN_INT = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MOD   = 3'd5;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   opa_q;      // multiplicand, or dividend/quotient shift register
    logic [DATA_W-1:0]   opb_q;      // multiplier, or divisor magnitude
    logic [DATA_W-1:0]   rem_q;
    logic                negq_q;
    logic                negr_q;
    logic [DATA_W-1:0]   result_q;
    logic [TAG_W-1:0]    tag_q;
    logic [TAG_W-1:0]    tagf_q;

    logic                     is_div_d, sdiv_d, special_d;
    logic [DATA_W-1:0]        abs1_d, abs2_d, spec_res_d;
    logic signed [2*DATA_W-1:0] ext_a_d, ext_b_d, prod_d;
    logic [DATA_W-1:0]        mul_res_d, quo_fix_d, rem_fix_d, fix_res_d;
    logic [DATA_W:0]          rem_sh_d, diff_d;

    // Issue-side decode and special-case results
    always_comb begin
        is_div_d   = (bus.op_i >= OP_DIV) && (bus.op_i != OP_RSVD);
        sdiv_d     = (bus.op_i == OP_DIV) || (bus.op_i == OP_MOD);
        abs1_d     = (sdiv_d && bus.src1_i[DATA_W-1]) ? -bus.src1_i : bus.src1_i;
        abs2_d     = (sdiv_d && bus.src2_i[DATA_W-1]) ? -bus.src2_i : bus.src2_i;
        special_d  = (bus.op_i == OP_RSVD)
                   || (is_div_d && (bus.src2_i == '0))
                   || (sdiv_d && (bus.src1_i == MIN_INT) && (bus.src2_i == '1));
        spec_res_d = '0;
        if (is_div_d) begin
            if ((bus.op_i == OP_DIV) || (bus.op_i == OP_DIVU))
                spec_res_d = (bus.src2_i == '0) ? '1 : MIN_INT;
            else
                spec_res_d = (bus.src2_i == '0) ? bus.src1_i : '0;
        end
    end

    // Multiply datapath: only MULH needs sign extension, the low half is sign-agnostic
    always_comb begin
        if (op_q == OP_MULH) begin
            ext_a_d = $signed({{DATA_W{opa_q[DATA_W-1]}}, opa_q});
            ext_b_d = $signed({{DATA_W{opb_q[DATA_W-1]}}, opb_q});
        end else begin
            ext_a_d = $signed({{DATA_W{1'b0}}, opa_q});
            ext_b_d = $signed({{DATA_W{1'b0}}, opb_q});
        end
        prod_d    = ext_a_d * ext_b_d;
        mul_res_d = (op_q == OP_MUL) ? prod_d[DATA_W-1:0] : prod_d[2*DATA_W-1:DATA_W];
    end

    // Divide datapath: one restoring step per cycle, sign fix-up afterwards
    always_comb begin
        rem_sh_d  = {rem_q, opa_q[DATA_W-1]};
        diff_d    = rem_sh_d - {1'b0, opb_q};
        quo_fix_d = negq_q ? -opa_q : opa_q;
        rem_fix_d = negr_q ? -rem_q : rem_q;
        fix_res_d = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quo_fix_d : rem_fix_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rem_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
            tagf_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i && !bus.flush_i) begin
                        op_q   <= bus.op_i;
                        tagf_q <= bus.tag_i;
                        rem_q  <= '0;
                        negq_q <= sdiv_d && (bus.src1_i[DATA_W-1] ^ bus.src2_i[DATA_W-1]);
                        negr_q <= sdiv_d && bus.src1_i[DATA_W-1];
                        if (special_d) begin
                            result_q <= spec_res_d;
                            tag_q    <= bus.tag_i;
                            state_q  <= S_DONE;
                        end else if (bus.op_i <= OP_MULHU) begin
                            opa_q   <= bus.src1_i;
                            opb_q   <= bus.src2_i;
                            cnt_q   <= CNT_W'(MUL_STAGES - 1);
                            state_q <= S_MUL;
                        end else begin
                            opa_q   <= abs1_d;
                            opb_q   <= abs2_d;
                            cnt_q   <= CNT_W'(DATA_W - 1);
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (bus.flush_i) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        result_q <= mul_res_d;
                        tag_q    <= tagf_q;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (bus.flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        opa_q <= {opa_q[DATA_W-2:0], ~diff_d[DATA_W]};
                        rem_q <= diff_d[DATA_W] ? rem_sh_d[DATA_W-1:0] : diff_d[DATA_W-1:0];
                        if (cnt_q == '0) state_q <= S_FIX;
                        else             cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (bus.flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        result_q <= fix_res_d;
                        tag_q    <= tagf_q;
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ready_o    = (state_q == S_IDLE);
    assign bus.busy_o     = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign bus.done_o     = (state_q == S_DONE) && !bus.flush_i;
    assign bus.stallreq_o = (bus.ready_o && bus.start_i && !bus.flush_i) || bus.busy_o;
    assign bus.result_o   = result_q;
    assign bus.tag_o      = tag_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed and random operations scored through a
// queue of expected results, plus flush, reset and back-to-back scenarios.
module tb_ex_muldiv_unit;
    localparam int DW = 32;
    localparam int TW = 5;
    localparam int MS = 2;
    localparam logic [DW-1:0] MINI = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.DATA_W(DW), .TAG_W(TW)) bus ();
    ex_muldiv_unit #(.DATA_W(DW), .MUL_STAGES(MS), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct packed {
        logic [DW-1:0] res;
        logic [TW-1:0] tag;
    } exp_t;

    typedef struct packed {
        logic [2:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] r;
        logic [5:0]    lat;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [DW-1:0] last_res = '0;
    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint sa, sb, sr;
        logic [63:0] ua, ub, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        ur = '0;
        sr = 0;
        case (op)
            3'd0: begin ur = ua * ub; return ur[31:0]; end
            3'd1: begin sr = sa * sb; ur = sr; return ur[63:32]; end
            3'd2: begin ur = ua * ub; return ur[63:32]; end
            3'd3: begin if (b == '0) return '1; sr = sa / sb; ur = sr; return ur[31:0]; end
            3'd4: begin if (b == '0) return '1; ur = ua / ub; return ur[31:0]; end
            3'd5: begin if (b == '0) return a; sr = sa % sb; ur = sr; return ur[31:0]; end
            3'd6: begin if (b == '0) return a; ur = ua % ub; return ur[31:0]; end
            default: return '0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (op == 3'd7) return 1;
        if (op <= 3'd2) return MS + 1;
        if (b == '0) return 1;
        if (((op == 3'd3) || (op == 3'd5)) && (a == MINI) && (b == '1)) return 1;
        return DW + 2;
    endfunction

    // Scoreboard: every done_o pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (bus.done_o === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done result=%h tag=%0d (no operation outstanding)", bus.result_o, bus.tag_o);
            end else begin
                mon_e = sb_q.pop_front();
                last_res = mon_e.res;
                if (bus.result_o !== mon_e.res || bus.tag_o !== mon_e.tag) begin
                    errors++;
                    $display("FAIL result got=%h/tag %0d expected=%h/tag %0d", bus.result_o, bus.tag_o, mon_e.res, mon_e.tag);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic drive(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] t);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        bus.tag_i   = t;
    endtask

    // Call in cycle 1 after the accepting edge; returns at the negedge of the done cycle.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.op_i = '0;
        bus.src1_i = '0; bus.src2_i = '0; bus.tag_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", bus.ready_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done_o); end
        checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", bus.stallreq_o); end
        checks++; if (bus.result_o !== '0 || bus.tag_o !== '0) begin errors++; $display("FAIL reset_result got=%h/%0d want=0/0", bus.result_o, bus.tag_o); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_mul_timing();
        drive(3'd0, 32'hFFFF_FFFD, 32'd5, 5'd7);
        sb_q.push_back({32'hFFFF_FFF1, 5'd7});
        @(negedge clk);
        checks++; if (bus.stallreq_o !== 1'b1) begin errors++; $display("FAIL mul_stall_c0 got=%b want=1", bus.stallreq_o); end
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int c = 1; c <= MS; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.stallreq_o, bus.busy_o, bus.done_o} !== 3'b110) begin
                errors++; $display("FAIL mul_busy_c%0d stall/busy/done got=%b want=110", c, {bus.stallreq_o, bus.busy_o, bus.done_o});
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if ({bus.stallreq_o, bus.busy_o, bus.done_o} !== 3'b001) begin
            errors++; $display("FAIL mul_done_c3 stall/busy/done got=%b want=001", {bus.stallreq_o, bus.busy_o, bus.done_o});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        vec_t vecs [0:11];
        int lat;
        vecs = '{
            {3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 6'd3},
            {3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6'd3},
            {3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 6'd3},
            {3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 6'd34},
            {3'd5, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 6'd34},
            {3'd4, 32'd100,       32'd7,         32'd14,        6'd34},
            {3'd6, 32'd100,       32'd7,         32'd2,         6'd34},
            {3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 6'd1},
            {3'd6, 32'd5,         32'd0,         32'd5,         6'd1},
            {3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 6'd1},
            {3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         6'd1},
            {3'd7, 32'd123,       32'd456,       32'd0,         6'd1}
        };
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, TW'(i));
            sb_q.push_back({vecs[i].r, TW'(i)});
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            wait_done(lat);
            checks++;
            if (lat != int'(vecs[i].lat)) begin
                errors++; $display("FAIL vec%0d_latency op=%0d got=%0d want=%0d", i, vecs[i].op, lat, vecs[i].lat);
            end
            checks++;
            if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL vec%0d_stall_in_done got=%b want=0", i, bus.stallreq_o); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [DW-1:0] a, b;
        int lat, sel;
        for (int i = 0; i < 24; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = '0;
            else if (sel == 1) begin a = MINI; b = '1; end
            else if (sel == 2) b = DW'($urandom_range(1, 15));
            drive(op, a, b, TW'(i + 3));
            sb_q.push_back({model(op, a, b), TW'(i + 3)});
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            wait_done(lat);
            checks++;
            if (lat != exp_lat(op, a, b)) begin
                errors++; $display("FAIL rand%0d_latency op=%0d got=%0d want=%0d", i, op, lat, exp_lat(op, a, b));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_div();
        logic [DW-1:0] prev;
        int lat;
        prev = last_res;
        drive(3'd3, 32'd1000, 32'd3, 5'd3);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.flush_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin errors++; $display("FAIL flush_c10 busy/done got=%b%b want=10", bus.busy_o, bus.done_o); end
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        drive(3'd0, 32'd6, 32'd7, 5'd11);
        sb_q.push_back({32'd42, 5'd11});
        @(negedge clk);
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready_c11 got=%b want=1", bus.ready_o); end
        checks++; if (bus.result_o !== prev || bus.tag_o === 5'd3) begin errors++; $display("FAIL flush_result_kept got=%h/%0d want=%h", bus.result_o, bus.tag_o, prev); end
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        wait_done(lat);
        checks++; if (lat != MS + 1) begin errors++; $display("FAIL flush_next_mul_latency got=%0d want=%0d", lat, MS + 1); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_done_idle();
        drive(3'd0, 32'd2, 32'd3, 5'd4);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (MS) begin @(posedge clk); #1; end
        bus.flush_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL flush_in_done done/busy got=%b%b want=00", bus.done_o, bus.busy_o); end
        checks++; if (bus.result_o !== 32'd6 || bus.tag_o !== 5'd4) begin errors++; $display("FAIL flush_in_done_result got=%h/%0d want=6/4", bus.result_o, bus.tag_o); end
        @(posedge clk); #1;
        drive(3'd4, 32'd9, 32'd2, 5'd5);
        @(negedge clk);
        checks++; if (bus.ready_o !== 1'b1 || bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL flush_start_idle ready/stall got=%b%b want=10", bus.ready_o, bus.stallreq_o); end
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL flush_start_rejected ready/busy got=%b%b want=10", bus.ready_o, bus.busy_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        drive(3'd4, 32'd100, 32'd7, 5'd1);
        sb_q.push_back({32'd14, 5'd1});
        @(posedge clk); #1;
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            bus.op_i   = 3'($urandom_range(0, 7));
            bus.src1_i = $urandom;
            bus.src2_i = $urandom;
            bus.tag_i  = 5'd31;
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        checks++; if (lat != DW + 2) begin errors++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, DW + 2); end
        @(posedge clk); #1;
        drive(3'd0, 32'd6, 32'd7, 5'd9);
        sb_q.push_back({32'd42, 5'd9});
        @(negedge clk);
        checks++; if (bus.ready_o !== 1'b1 || bus.stallreq_o !== 1'b1) begin errors++; $display("FAIL b2b_accept_after_done ready/stall got=%b%b want=11", bus.ready_o, bus.stallreq_o); end
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        wait_done(lat);
        checks++; if (lat != MS + 1) begin errors++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, MS + 1); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_div();
        bit seen;
        drive(3'd3, 32'd50, 32'd5, 5'd6);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.result_o !== '0 || bus.tag_o !== '0) begin errors++; $display("FAIL rst_mid_result got=%h/%0d want=0/0", bus.result_o, bus.tag_o); end
        checks++; if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ready/busy got=%b%b want=10", bus.ready_o, bus.busy_o); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rst_mid_no_done got=1 want=0"); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_vectors();
        test_random();
        test_flush_div();
        test_flush_done_idle();
        test_back_to_back();
        test_reset_mid_div();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain outstanding=%0d want=0", sb_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit for the execution stage.
- Replaces the single-cycle `*`, `/` and `%` arithmetic path with a parameterised multiplier whose latency is set by a parameter and a radix-2 iterative divider.
- Adds signed/unsigned variants, defined divide-by-zero and overflow results, flush/cancel, and a stall request toward pipeline control.
- One operation in flight at a time.

Parameters:
- DATA_W, 32: operand and result width; must be ≥ 4.
- MUL_STAGES, 2: multiply latency in cycles; must be ≥ 1.
- TAG_W, 5: width of the destination-register tag carried with each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request to issue an operation.
- op_i  in  3  operation code: 0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 MOD, 6 MODU, 7 reserved.
- src1_i  in  DATA_W  dividend / multiplicand.
- src2_i  in  DATA_W  divisor / multiplier.
- tag_i  in  TAG_W  destination register address.
- flush_i  in  1  cancel the in-flight operation.
- ready_o  out  1  high when state is IDLE.
- busy_o  out  1  high when state is MUL, DIV or FIX.
- stallreq_o  out  1  stall request to pipeline control.
- done_o  out  1  one-cycle result-valid pulse.
- result_o  out  DATA_W  result value.
- tag_o  out  TAG_W  tag of the completed operation.

Behaviour:
- States: IDLE, MUL, DIV, FIX, DONE.
- Reset: state IDLE. result_o, tag_o, the internal counter and all datapath registers clear to 0. done_o = 0, busy_o = 0, ready_o = 1.
- Accept: on a rising edge where state == IDLE, start_i = 1 and flush_i = 0. src1_i, src2_i, op_i and tag_i are captured at that edge.
- start_i while not IDLE is ignored and must not corrupt the operation in flight.
- Latency L is counted from the accepting edge; done_o is high during cycle L.
  - MUL / MULH / MULHU: L = MUL_STAGES + 1. Path IDLE → MUL for MUL_STAGES cycles → DONE.
  - DIV / DIVU / MOD / MODU, normal case: L = DATA_W + 2. Path IDLE → DIV (DATA_W cycles, one quotient bit per cycle) → FIX (1 cycle, sign correction) → DONE.
  - Special cases (divisor = 0, signed overflow, op 7): L = 1. Path IDLE → DONE directly.
- DONE lasts exactly one cycle, then returns to IDLE. A new operation can be accepted in the cycle after DONE.
- result_o and tag_o update on entry to DONE and hold until the next DONE.
- done_o = (state == DONE) & ~flush_i.
- stallreq_o = (state == IDLE & start_i & ~flush_i) | busy_o. Deasserted during DONE so the stage advances with the result.
- Arithmetic:
  - MUL: low DATA_W bits of the product; identical for signed and unsigned.
  - MULH: high DATA_W bits of the signed 2·DATA_W product.
  - MULHU: high DATA_W bits of the unsigned 2·DATA_W product.
  - Signed division: operate on magnitudes. Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend (truncating division).
  - Divide by zero: DIV/DIVU give all-ones; MOD/MODU give src1 unchanged.
  - Signed overflow (src1 = MIN_INT, src2 = −1, DIV/MOD only): quotient = MIN_INT, remainder = 0.
  - op 7: result 0.
- Flush:
  - flush_i in MUL/DIV/FIX: state goes to IDLE at the next edge. No done_o is produced for that operation; result_o and tag_o are unchanged.
  - flush_i in IDLE together with start_i: the start is not accepted.
  - flush_i in DONE: done_o is suppressed that cycle; state still returns to IDLE.
- Reset mid-operation: same effect as flush, plus result_o and tag_o clear to 0.

Test Plan:
- MUL −3 × 5 (MUL_STAGES = 2), tag 7 → done_o in cycle 3 after accept, result 0xFFFFFFF1, tag_o 7; stallreq_o high in cycles 0–2, low in cycle 3.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MUL of the same operands → 0x00000001.
- DIV −7 / 2 → 0xFFFFFFFD and MOD −7 % 2 → 0xFFFFFFFF, each with done_o in cycle 34. DIVU 100 / 7 → 14. MODU 100 % 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and MODU 5 / 0 → 5, both at L = 1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. MOD with the same operands → 0, at L = 1.
- Start a DIV, assert flush_i in cycle 10 → no done_o, ready_o = 1 in cycle 11. A MUL 6 × 7 issued in cycle 11 → 42 at L = 3.
- Hold start_i high continuously with changing operands during a DIV → only the first operation completes, then the next is accepted in the cycle after DONE. Assert rst during DIV → result_o = 0 and ready_o = 1 after the edge.
